// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite renderers, the shared sprite ROM and the arbiter.
// The slave modport is the arbiter; the master modport is the renderers plus the ROM.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*ADDR_W-1:0] i_req_addr;
  logic [N_REQ-1:0]        o_gnt;
  logic [ADDR_W-1:0]       o_rom_addr;
  logic [DATA_W-1:0]       i_rom_data;
  logic [N_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]       o_rdata;
  logic                    o_busy;

  modport slave (
    input  i_req, i_req_addr, i_rom_data,
    output o_gnt, o_rom_addr, o_rvalid, o_rdata, o_busy
  );

  modport master (
    output i_req, i_req_addr, i_rom_data,
    input  o_gnt, o_rom_addr, o_rvalid, o_rdata, o_busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among N_REQ pixel fetchers.
// Returns each read's data with a one-hot valid to its owner two edges after acceptance.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic                 i_clk2,
  input logic                 i_rst_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  last_q;
  logic [IDX_W-1:0]  win_idx_p0;
  logic [N_REQ-1:0]  gnt_p0;
  logic              acc_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [IDX_W:0]    cand;

  logic [ADDR_W-1:0] rom_addr_p1;
  logic              vld_p1;
  logic [IDX_W-1:0]  tag_p1;

  logic [N_REQ-1:0]  rvalid_p2;
  logic [N_REQ-1:0]  rvalid_d;
  logic              busy_q;

  // Stage 0: combinational arbitration, search starts just after the last winner.
  always_comb begin
    gnt_p0     = '0;
    win_idx_p0 = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i + 1);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (gnt_p0 == '0 && bus.i_req[cand[IDX_W-1:0]]) begin
        gnt_p0[cand[IDX_W-1:0]] = 1'b1;
        win_idx_p0              = cand[IDX_W-1:0];
      end
    end
  end

  assign acc_p0 = |gnt_p0;

  always_comb begin
    sel_addr_p0 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_p0[k]) sel_addr_p0 = bus.i_req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Stage 1: ROM address register and in-flight owner tag.
  always_ff @(posedge i_clk2) begin
    if (!i_rst_n) begin
      last_q      <= IDX_W'(N_REQ - 1);
      rom_addr_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (acc_p0) begin
        last_q      <= win_idx_p0;
        rom_addr_p1 <= sel_addr_p0;
      end
      vld_p1 <= acc_p0;
    end
  end

  // The tag is only meaningful while vld_p1 is high, so it carries no reset.
  always_ff @(posedge i_clk2) begin
    if (acc_p0) tag_p1 <= win_idx_p0;
  end

  always_comb begin
    rvalid_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rvalid_d[k] = vld_p1 && (tag_p1 == IDX_W'(k));
    end
  end

  // Stage 2: valid lines up with the ROM's registered read of rom_addr_p1.
  always_ff @(posedge i_clk2) begin
    if (!i_rst_n) begin
      rvalid_p2 <= '0;
      busy_q    <= 1'b0;
    end else begin
      rvalid_p2 <= rvalid_d;
      busy_q    <= acc_p0 | vld_p1;
    end
  end

  assign bus.o_gnt      = gnt_p0;
  assign bus.o_rom_addr = rom_addr_p1;
  assign bus.o_rvalid   = rvalid_p2;
  assign bus.o_rdata    = bus.i_rom_data;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: vector table of grants plus a scoreboard of expected returns.
// A behavioural sprite ROM with a one-cycle registered read sits on the bus.
module tb_sprite_rom_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;

  sprite_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk2 (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [9:0] a);
    logic [9:0] t;
    t = a * 10'd37 + 10'd11;
    return t[7:0] ^ {a[9:8], 6'h15};
  endfunction

  always @(posedge clk) bus.i_rom_data <= rom_val(bus.o_rom_addr);

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [39:0] addr;
    logic [3:0]  gnt;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [7:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  logic acc_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] pack(input logic [9:0] a0, input logic [9:0] a1,
                                       input logic [9:0] a2, input logic [9:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic add(input logic rst, input logic [3:0] req, input logic [39:0] addr,
                     input logic [3:0] gnt);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.gnt = gnt;
    vecs.push_back(v);
  endtask

  // One clock: drive inputs, check the combinational grant, then check registered outputs.
  task automatic apply(input logic rst, input logic [3:0] req, input logic [39:0] addr,
                       input logic [3:0] exp_gnt, input string nm);
    logic       acc;
    logic [9:0] waddr;
    logic [3:0] exp_rv;
    logic [7:0] exp_rd;
    exp_t       e;
    rst_n          = ~rst;
    bus.i_req      = req;
    bus.i_req_addr = addr;
    #1;
    chk({nm, " gnt"}, 32'(bus.o_gnt), 32'(exp_gnt));
    waddr = '0;
    for (int k = 0; k < N_REQ; k++) if (exp_gnt[k]) waddr = addr[k*ADDR_W +: ADDR_W];
    acc = |exp_gnt;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      acc_prev = 1'b0;
      chk({nm, " rst rvalid"}, 32'(bus.o_rvalid), 32'd0);
      chk({nm, " rst busy"}, 32'(bus.o_busy), 32'd0);
      chk({nm, " rst rom_addr"}, 32'(bus.o_rom_addr), 32'd0);
    end else begin
      if (acc) begin
        e.due = cyc + 1; e.oh = exp_gnt; e.data = rom_val(waddr);
        sb.push_back(e);
        chk({nm, " rom_addr"}, 32'(bus.o_rom_addr), 32'(waddr));
      end
      exp_rv = '0;
      exp_rd = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_rv = sb[0].oh;
        exp_rd = sb[0].data;
        void'(sb.pop_front());
      end
      chk({nm, " rvalid"}, 32'(bus.o_rvalid), 32'(exp_rv));
      if (exp_rv != 4'd0) chk({nm, " rdata"}, 32'(bus.o_rdata), 32'(exp_rd));
      chk({nm, " busy"}, 32'(bus.o_busy), 32'(acc | acc_prev));
      acc_prev = acc;
    end
  endtask

  initial begin
    logic [39:0] all4;
    logic [39:0] none;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    acc_prev = 1'b0;
    rst_n    = 1'b0;
    bus.i_req      = '0;
    bus.i_req_addr = '0;
    all4 = pack(10'h011, 10'h122, 10'h233, 10'h344);
    none = '0;

    add(1, 4'b0000, none, 4'b0000);
    add(0, 4'b0001, pack(10'h123, 0, 0, 0), 4'b0001);
    add(0, 4'b0000, none, 4'b0000);
    add(0, 4'b0000, none, 4'b0000);
    add(1, 4'b0000, none, 4'b0000);
    add(0, 4'b1111, all4, 4'b0001);
    add(0, 4'b1111, all4, 4'b0010);
    add(0, 4'b1111, all4, 4'b0100);
    add(0, 4'b1111, all4, 4'b1000);
    add(0, 4'b1111, all4, 4'b0001);
    add(0, 4'b0100, all4, 4'b0100);
    add(0, 4'b0101, all4, 4'b0001);
    add(0, 4'b0000, none, 4'b0000);
    for (int a = 0; a < 4; a++) add(0, 4'b0010, pack(0, 10'(a), 0, 0), 4'b0010);
    add(0, 4'b0000, none, 4'b0000);
    add(0, 4'b0000, none, 4'b0000);
    add(0, 4'b0000, none, 4'b0000);
    add(0, 4'b1001, all4, 4'b1000);
    add(0, 4'b1001, all4, 4'b0001);
    add(0, 4'b0000, none, 4'b0000);
    add(0, 4'b0000, none, 4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].req, vecs[i].addr, vecs[i].gnt, $sformatf("vec%0d", i));

    // Reset one cycle after an accept drops the in-flight read.
    apply(0, 4'b0001, pack(10'h055, 0, 0, 0), 4'b0001, "midrst_acc");
    apply(1, 4'b0000, none, 4'b0000, "midrst_rst");
    apply(0, 4'b1111, all4, 4'b0001, "midrst_after");
    apply(0, 4'b0000, none, 4'b0000, "midrst_idle0");
    apply(0, 4'b0000, none, 4'b0000, "midrst_idle1");
    apply(0, 4'b0000, none, 4'b0000, "midrst_idle2");

    // Requester 3 withdraws before it is ever served.
    apply(1, 4'b0000, none, 4'b0000, "drop_rst");
    apply(0, 4'b1011, all4, 4'b0001, "drop_a");
    apply(0, 4'b0010, all4, 4'b0010, "drop_b");
    apply(0, 4'b0000, none, 4'b0000, "drop_idle0");
    apply(0, 4'b0000, none, 4'b0000, "drop_idle1");
    apply(0, 4'b0000, none, 4'b0000, "drop_idle2");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares one single-port, synchronous-read sprite ROM (10-bit address, 8-bit pixel data, one-cycle registered read) among several pixel-fetch requesters, e.g. the player, enemy and projectile sprite renderers. It accepts at most one address per clock, drives the ROM address, tracks which requester owns each in-flight read, and returns the ROM data with a one-hot valid to the owner. It sits between the sprite renderers and the ROM, in the pixel clock domain.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ADDR_W, 10: ROM address width.
- DATA_W, 8: ROM pixel data width.

- i_clk2  input  1  pixel clock; all logic is on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_req  input  N_REQ  per-requester request; held high with a stable address until granted.
- i_req_addr  input  N_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- o_gnt  output  N_REQ  one-hot combinational grant; a transfer occurs on an edge where i_req[k] & o_gnt[k].
- o_rom_addr  output  ADDR_W  registered address to the ROM.
- i_rom_data  input  DATA_W  ROM registered read data.
- o_rvalid  output  N_REQ  one-hot, registered: o_rdata belongs to requester k this cycle.
- o_rdata  output  DATA_W  equals i_rom_data (combinational pass-through).
- o_busy  output  1  registered; high while any read is in flight.

## Operation
- Arbitration, combinational: winner = the first asserted i_req[k] searching from index (last+1) mod N_REQ upward with wrap-around. o_gnt is the one-hot winner and is all-zero when i_req is zero. o_gnt never depends on the grant pointer's next-state value.
- On accept, i.e. at an edge with any o_gnt bit set:
  - o_rom_addr <= winner's address.
  - last <= winner index.
  - stage-1 valid s1_v <= 1 and s1_tag <= winner index.
- With no accept, s1_v <= 0, and o_rom_addr and last hold their values.
- Stage 2, every edge:
  - o_rvalid <= s1_v ? onehot(s1_tag) : 0.
  - This aligns with the ROM registering mem[o_rom_addr].
- o_busy <= (accept this edge) | s1_v.
- One accept per cycle, so throughput is one read per clock. A requester holding i_req continuously is granted at least once every N_REQ cycles.
- A requester may drop i_req before it is granted. No transfer occurs, and no state changes on its behalf.
- Simultaneous accept and return: an accept and an o_rvalid pulse for a different requester (or the same one) in one cycle are legal and independent.

## Timing
- Reset (i_rst_n low at an edge): last <= N_REQ-1, so requester 0 has first priority. s1_v, o_rvalid and o_busy <= 0, and o_rom_addr <= 0. o_gnt is not masked during reset, but transfers during reset cycles are discarded.
- Reset mid-operation: in-flight reads are dropped. No o_rvalid pulses appear after reset for reads accepted before it.
- Latency: for accept at edge E0, o_rom_addr is updated after E0. The ROM data and o_rvalid[k] are valid in the cycle after E1, which is 2 edges after the accept.
- o_rvalid is high for exactly one cycle per accepted request. Pulse order equals accept order.

## Test plan
- Reset then i_req=4'b0001, addr0=10'h123: o_gnt=0001 in the same cycle. o_rom_addr=0x123 after the first edge. o_rvalid=0001 with o_rdata=mem[0x123] after the second edge, then o_rvalid=0.
- All four requesters held high with distinct addresses from reset: grants run 0,1,2,3,0,… on consecutive cycles. o_rvalid follows the same sequence 2 cycles later, with each o_rdata matching that requester's address.
- After requester 2 is granted, i_req=4'b0101: the next grant goes to 0 (wrap-around past index 3), not to 2.
- Back-to-back reads from requester 1 at addresses 0,1,2,3: o_rvalid=0010 stays high for 4 consecutive cycles with mem[0..3] in order. o_busy stays high throughout and drops 1 cycle after the last o_rvalid.
- Reset asserted one cycle after an accept: no o_rvalid pulse appears. After release, requester 0 wins when i_req=1111.
- Requester 3 raises i_req, then drops it the same cycle that requesters 0 and 1 win: no transfer or o_rvalid ever occurs for 3.
